// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard RAW hazard, stall and flush-drain control.
// Optional stall counter port enabled by HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
  parameter int ADDR_LEN   = 5,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                id_valid,
  input  logic [ADDR_LEN-1:0] id_oper1,
  input  logic [ADDR_LEN-1:0] id_oper2,
  input  logic [ADDR_LEN-1:0] id_dest,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic                bubble,
  output logic                busy,
  output logic                drained,
  output logic [1:0]          state
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                v;
    logic [ADDR_LEN-1:0] addr;
  } sb_ent_t;

  sb_ent_t sb [PIPE_DEPTH];
  state_t  st;
  logic    hit;
  logic    hazard;

  always_comb begin
    hit  = 1'b0;
    busy = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      busy = busy | sb[k].v;
      if (sb[k].v &&
          (sb[k].addr == id_oper1 ||
           sb[k].addr == id_oper2))
        hit = 1'b1;
    end
  end

  assign hazard = id_valid & hit;
  assign stall  = hazard | flush | (st == DRAIN);
  assign issue  = id_valid & ~stall;
  assign bubble = ~issue;
  assign state  = st;

  // entry 0 is youngest; the oldest retires off the end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < PIPE_DEPTH; k++)
        sb[k] <= '0;
    end else begin
      sb[0] <= '{v: issue, addr: id_dest};
      for (int k = 1; k < PIPE_DEPTH; k++)
        sb[k] <= sb[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st      <= RUN;
      drained <= 1'b0;
    end else begin
      drained <= 1'b0;
      unique case (st)
        RUN, STALL: begin
          if (flush)       st <= DRAIN;
          else if (hazard) st <= STALL;
          else             st <= RUN;
        end
        DRAIN: begin
          if (!busy) begin
            st      <= RUN;
            drained <= 1'b1;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (stall && id_valid &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Scoreboard-based RAW hazard and stall controller for the 4-stage IF/ID/ALU/WB pipeline.
- Tracks destination registers of in-flight instructions between ID issue and register-file write.
- Compares each decoded instruction's source operands against them and stalls IF/ID, injecting bubbles into the ALU stage, until the producing write has retired.
- A flush request drains the pipeline and reports completion.

Parameters:
ADDR_LEN, 5, register address width
PIPE_DEPTH, 3, cycles from ID issue until the register write has completed (ID->ALU->WB->regfile)

Ports:
clk  input  1  clock
rstn  input  1  reset; synchronous, active-low
id_valid  input  1  valid decoded instruction present in ID
id_oper1  input  ADDR_LEN  source register 1 of ID instruction
id_oper2  input  ADDR_LEN  source register 2 of ID instruction
id_dest  input  ADDR_LEN  destination register of ID instruction
flush  input  1  level request to drain pipeline
stall  output  1  hold IF and ID registers this cycle (combinational)
issue  output  1  ID instruction advances to ALU this cycle (combinational)
bubble  output  1  ALU stage receives NOP this cycle (combinational)
busy  output  1  any scoreboard entry valid (combinational from registers)
drained  output  1  one-cycle pulse: flush drain completed (registered)
state  output  2  FSM state: 0 RUN, 1 STALL, 2 DRAIN (registered)

Behaviour:
- Scoreboard: PIPE_DEPTH entries {v, addr}, index 0 youngest.
  - Every edge: entry[0] <= {issue, id_dest}; entry[k] <= entry[k-1].
  - The oldest entry falls off.
- hazard = id_valid AND some k in 0..PIPE_DEPTH-1 has v[k] AND (addr[k]==id_oper1 OR addr[k]==id_oper2).
  - All addresses are real registers; no zero-register exemption.
  - oper1==oper2 is legal and counts as a single match.
- stall = hazard OR flush OR (state==DRAIN).
- issue = id_valid AND NOT stall.
- bubble = NOT issue.
- busy = OR of all v[k].
- An instruction whose producer sits in entry[k] when it arrives stalls exactly PIPE_DEPTH-k cycles, then issues.
- FSM, evaluated at each edge, flush has priority over hazard:
  - RUN: flush -> DRAIN; else hazard -> STALL; else RUN.
  - STALL: flush -> DRAIN; else hazard clear -> RUN (issue is already high in that final cycle); else STALL.
  - DRAIN: no issue; bubbles shift in. When busy==0 at an edge -> RUN and drained=1 next cycle only; else DRAIN.
- flush held high after drained keeps stall asserted. Because busy stays 0, the FSM re-enters DRAIN and pulses drained every second cycle.
- Instructions in ID during a flush are held, not discarded. The instruction source decides whether to invalidate them.
- STALL may not persist more than PIPE_DEPTH consecutive cycles. The bench must check this with an assertion.
- Reset (rstn=0 at edge):
  - all v cleared;
  - state=RUN; drained=0;
  - stats counter cleared (see Optional Feature).
- Reset while in DRAIN or STALL returns to RUN with no drained pulse.
- Outputs with id_valid=0 and no flush: stall=0, issue=0, bubble=1.

Optional Feature:
- Macro: HAZARD_CTRL_STATS_EN.
- When defined: adds output stall_cnt, 16 bits, registered.
  - Increments by 1 on every edge where stall=1 AND id_valid=1.
  - Saturates at 16'hFFFF; cleared by reset.
  - Flush-only stall cycles with id_valid=0 are not counted.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Back-to-back RAW: issue A dest=3, next cycle B oper1=3 -> stall=1 for 3 cycles, state=STALL; B issues on 4th cycle and state returns to RUN.
- Distance-2 RAW on oper2: A dest=7, independent instruction, then C oper2=7 -> exactly 2 stall cycles, then issue.
- Independent stream: 10 instructions with no overlapping registers -> stall never 1, issue=1 every cycle, busy=1 from the 2nd cycle.
- Flush with 2 in-flight: one-cycle flush pulse -> state=DRAIN, bubble=1, busy falls 2-3 cycles later; drained=1 exactly one cycle; state=RUN afterward.
- Reset mid-DRAIN: rstn=0 for one edge -> busy=0, state=RUN, drained never pulses, stall_cnt=0 (with HAZARD_CTRL_STATS_EN).
- Stats: the back-to-back RAW scenario twice -> stall_cnt=6. Force the counter to 16'hFFFE, then 3 valid stall cycles -> counter holds 16'hFFFF.
